// File: rtl/regfile_pkg.sv
// Shared types for the pipelined multi-port register file.
//   rf_state_e : clear-sequencer state (sweeping vs. usable)
//   RF_MAX_RD  : largest supported number of read ports
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_e;

  localparam int RF_MAX_RD = 4;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for the register file: after reset, or on a clr_req pulse,
// walks a counter over every entry (one entry per cycle) and then reports the
// file as usable.
// Ports:
//   clk       clock, all state on posedge
//   reset     asynchronous active-low reset (forces a new sweep from entry 0)
//   clr_req   one-cycle request to (re)start a sweep
//   clr_we    1 while sweeping: the array entry clr_addr is written with 0
//   clr_addr  entry being cleared this cycle
//   ready     registered, 1 once the sweep has finished
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_e         state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RF_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (clr_req) begin
            cnt <= '0;
          end else if (cnt == '1) begin
            // last entry is written on this edge; counter never wraps
            state <= RF_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        RF_IDLE: begin
          if (clr_req) begin
            state <= RF_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= RF_CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp_pipelined.sv
// Architectural integer register file: one write port, N_RD read ports.
// Inputs are registered (stage 1) and read data is registered (stage 2), so
// a read address presented before edge N returns data after edge N+1.
// Optional write-to-read bypass and hardwired-zero entry 0. A clear sequencer
// zeroes every entry after reset or on clr_req; user writes are dropped and
// reads return 0 while it runs.
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset
//   we       write enable
//   waddr    write address
//   wbdata   write data
//   rs_addr  packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rs_data  packed read data,      port i = [i*DATA_W +: DATA_W]
//   clr_req  one-cycle pulse requesting a full clear sweep
//   ready    1 = file usable, 0 = clearing
module regfile_mp_pipelined
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wbdata,
  input  logic [N_RD*ADDR_W-1:0] rs_addr,
  output logic [N_RD*DATA_W-1:0] rs_data,
  input  logic                   clr_req,
  output logic                   ready
);

  localparam int DEPTH = 1 << ADDR_W;

  // Stage 1 input registers
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wbdata_q;
  logic [ADDR_W-1:0] raddr_q [N_RD];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wbdata_q <= '0;
      for (int unsigned i = 0; i < N_RD; i++) raddr_q[i] <= '0;
    end else begin
      we_q     <= we;
      waddr_q  <= waddr;
      wbdata_q <= wbdata;
      for (int unsigned i = 0; i < N_RD; i++) raddr_q[i] <= rs_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Clear sequencer
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Write mux: the sweep owns the array port while clearing
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign user_we = we_q && !clr_we && !((ZERO_REG != 0) && (waddr_q == '0));

  always_comb begin
    mem_we = clr_we | user_we;
    mem_wa = clr_we ? clr_addr : waddr_q;
    mem_wd = clr_we ? '0 : wbdata_q;
  end

  // Storage array, intentionally not reset
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read ports: precedence clearing > zero entry > bypass > array
  for (genvar i = 0; i < N_RD && i < RF_MAX_RD; i++) begin : g_rd
    logic [DATA_W-1:0] rd_nxt;
    logic [DATA_W-1:0] rd_q;

    always_comb begin
      rd_nxt = mem[raddr_q[i]];
      if ((BYPASS != 0) && we_q && (waddr_q == raddr_q[i])) rd_nxt = wbdata_q;
      if ((ZERO_REG != 0) && (raddr_q[i] == '0)) rd_nxt = '0;
      if (clr_we) rd_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_nxt;
    end

    assign rs_data[i*DATA_W +: DATA_W] = rd_q;
  end

endmodule
